// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: programmable divisor, 5-8 data bits, optional parity,
// 1 or 2 stop bits, 3-sample majority vote, false-start rejection and break detection.
module uart_rx_cfg #(
    parameter int unsigned CLK_FREQ = 24_000_000,
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned DIV_W    = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             rx,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    input  logic             cfg_stop2,
    output logic [7:0]       po_data,
    output logic             po_flag,
    output logic             po_parity_err,
    output logic             po_frame_err,
    output logic             po_break,
    output logic             busy
);

    // The divisor shadow resets to the suggested default; it is reloaded on every start edge.
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ / UART_BPS);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(8);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    state_e state_q, state_d;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic fall;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       last_idx_q, last_idx_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             stop2_q, stop2_d;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic [7:0]       data_q, data_d;
    logic             zero_q, zero_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;

    logic [7:0] po_data_q, po_data_d;
    logic       po_flag_q, po_flag_d;
    logic       po_perr_q, po_perr_d;
    logic       po_ferr_q, po_ferr_d;
    logic       po_brk_q, po_brk_d;

    logic [DIV_W-1:0] half;
    logic             at_s0, at_s1, at_dec, bit_end;
    logic             vote;

    assign fall    = rx_prev_q & ~rx_sync_q;
    assign half    = div_q >> 1;
    assign at_s0   = (cnt_q == half - ONE);
    assign at_s1   = (cnt_q == half);
    assign at_dec  = (cnt_q == half + ONE);
    assign bit_end = (cnt_q == div_q - ONE);
    assign vote    = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            div_q      <= DIV_RST;
            last_idx_q <= 3'd7;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            data_q     <= '0;
            zero_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            po_data_q  <= '0;
            po_flag_q  <= 1'b0;
            po_perr_q  <= 1'b0;
            po_ferr_q  <= 1'b0;
            po_brk_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            div_q      <= div_d;
            last_idx_q <= last_idx_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            stop2_q    <= stop2_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            data_q     <= data_d;
            zero_q     <= zero_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            po_data_q  <= po_data_d;
            po_flag_q  <= po_flag_d;
            po_perr_q  <= po_perr_d;
            po_ferr_q  <= po_ferr_d;
            po_brk_q   <= po_brk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        last_idx_d = last_idx_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        data_d     = data_q;
        zero_d     = zero_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        po_data_d  = po_data_q;
        po_flag_d  = 1'b0;
        po_perr_d  = po_perr_q;
        po_ferr_d  = po_ferr_q;
        po_brk_d   = po_brk_q;

        if (state_q != StIdle && state_q != StBrkWait) begin
            cnt_d = bit_end ? '0 : cnt_q + ONE;
            if (at_s0) s0_d = rx_sync_q;
            if (at_s1) s1_d = rx_sync_q;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) begin
                    state_d    = StStart;
                    div_d      = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
                    last_idx_d = 3'd4 + {1'b0, cfg_data_bits};
                    par_en_d   = cfg_parity_en;
                    par_odd_d  = cfg_parity_odd;
                    stop2_d    = cfg_stop2;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    data_d     = '0;
                    zero_d     = 1'b1;
                    ferr_d     = 1'b0;
                    perr_d     = 1'b0;
                end
            end
            StStart: begin
                if (at_dec && vote) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (at_dec) begin
                    data_d[bit_idx_q] = vote;
                    if (vote) zero_d = 1'b0;
                end
                if (bit_end) begin
                    if (bit_idx_q == last_idx_q) begin
                        state_d    = par_en_q ? StParity : StStop;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (at_dec) begin
                    perr_d = vote ^ (^data_q) ^ par_odd_q;
                    if (vote) zero_d = 1'b0;
                end
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                // Report at the vote of the final stop bit so a back-to-back start is not missed.
                if (at_dec) begin
                    ferr_d = ferr_q | ~vote;
                    if (!stop_idx_q && !vote && zero_q) begin
                        state_d   = StBrkWait;
                        cnt_d     = '0;
                        po_flag_d = 1'b1;
                        po_data_d = data_q;
                        po_perr_d = perr_q;
                        po_ferr_d = 1'b1;
                        po_brk_d  = 1'b1;
                    end else if (stop_idx_q == stop2_q) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        po_flag_d = 1'b1;
                        po_data_d = data_q;
                        po_perr_d = perr_q;
                        po_ferr_d = ferr_q | ~vote;
                        po_brk_d  = 1'b0;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            StBrkWait: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign po_data       = po_data_q;
    assign po_flag       = po_flag_q;
    assign po_parity_err = po_perr_q;
    assign po_frame_err  = po_ferr_q;
    assign po_break      = po_brk_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are bit-banged onto rx and each po_flag pulse is
// captured by a monitor; scenario tasks compare captured fields against hand-computed values.
module tb_uart_rx_cfg;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        rx;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_data_bits;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic        cfg_stop2;
    logic [7:0]  po_data;
    logic        po_flag;
    logic        po_parity_err;
    logic        po_frame_err;
    logic        po_break;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] dq[$];
    logic       pq[$];
    logic       fq[$];
    logic       bq[$];

    uart_rx_cfg #(
        .CLK_FREQ(24_000_000),
        .UART_BPS(9600),
        .DIV_W   (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .rx            (rx),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .po_data       (po_data),
        .po_flag       (po_flag),
        .po_parity_err (po_parity_err),
        .po_frame_err  (po_frame_err),
        .po_break      (po_break),
        .busy          (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (po_flag) begin
            dq.push_back(po_data);
            pq.push_back(po_parity_err);
            fq.push_back(po_frame_err);
            bq.push_back(po_break);
        end
    end

    task automatic drive(input logic b, input int n);
        #1 rx = b;
        repeat (n) @(posedge sys_clk);
    endtask

    task automatic set_cfg(input int div, input logic [1:0] db, input logic pen,
                           input logic podd, input logic s2);
        cfg_div        = 16'(div);
        cfg_data_bits  = db;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
    endtask

    // gl_bit selects a data bit that gets a one-cycle inverted pulse at its middle sample.
    task automatic send_frame(input logic [7:0] d, input int n, input logic pen, input logic pbit,
                              input int nstop, input logic s1, input logic s2, input int div,
                              input int gl_bit);
        drive(1'b0, div);
        for (int i = 0; i < n; i++) begin
            if (i == gl_bit) begin
                drive(d[i], 9);
                drive(~d[i], 1);
                drive(d[i], div - 10);
            end else begin
                drive(d[i], div);
            end
        end
        if (pen) drive(pbit, div);
        drive(s1, div);
        if (nstop == 2) drive(s2, div);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        rx        = 1'b1;
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        n_checks++;
        if (po_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_po_data: got %h expected %h", po_data, 8'h00);
        end
        n_checks++;
        if (po_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_po_flag: got %b expected 0", po_flag);
        end
        n_checks++;
        if ({po_parity_err, po_frame_err, po_break} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_errors: got %b%b%b expected 000",
                     po_parity_err, po_frame_err, po_break);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        drive(1'b1, 10);
    endtask

    task automatic test_back_to_back;
        int base;
        base = dq.size();
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 2", dq.size() - base);
        end
        n_checks++;
        if (dq[base] !== 8'h55) begin
            n_fail++; $display("FAIL b2b_data0: got %h expected 55", dq[base]);
        end
        n_checks++;
        if (dq[base+1] !== 8'hA3) begin
            n_fail++; $display("FAIL b2b_data1: got %h expected a3", dq[base+1]);
        end
        n_checks++;
        if ({pq[base], fq[base], bq[base], pq[base+1], fq[base+1], bq[base+1]} !== 6'b0) begin
            n_fail++; $display("FAIL b2b_errors: got nonzero error flags expected 0");
        end
    endtask

    task automatic test_parity;
        int base;
        base = dq.size();
        // 0x41 has two ones: even parity bit is 0, odd parity bit is 1.
        set_cfg(16, 2'd2, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1, 1'b1, 16, -1);
        drive(1'b1, 20);
        set_cfg(16, 2'd2, 1'b1, 1'b1, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1, 1'b1, 16, -1);
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 2) begin
            n_fail++; $display("FAIL parity_count: got %0d expected 2", dq.size() - base);
        end
        n_checks++;
        if (dq[base] !== 8'h41 || pq[base] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_even_err: got data %h perr %b expected 41 1", dq[base], pq[base]);
        end
        n_checks++;
        if (dq[base+1] !== 8'h41 || pq[base+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_odd_ok: got data %h perr %b expected 41 0",
                     dq[base+1], pq[base+1]);
        end
    endtask

    task automatic test_stop_bits;
        int base;
        base = dq.size();
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b1);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0, 16, -1);
        drive(1'b1, 20);
        set_cfg(16, 2'd0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 2) begin
            n_fail++; $display("FAIL stop_count: got %0d expected 2", dq.size() - base);
        end
        n_checks++;
        if (dq[base] !== 8'hC3 || fq[base] !== 1'b1 || bq[base] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop2_frame_err: got data %h ferr %b brk %b expected c3 1 0",
                     dq[base], fq[base], bq[base]);
        end
        n_checks++;
        if (dq[base+1] !== 8'h1F || fq[base+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL five_bit_data: got data %h ferr %b expected 1f 0",
                     dq[base+1], fq[base+1]);
        end
    endtask

    task automatic test_glitch;
        int base;
        base = dq.size();
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3);
        drive(1'b1, 40);
        @(negedge sys_clk);
        n_checks++;
        if (dq.size() != base || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL false_start: got flags %0d busy %b expected 0 0", dq.size() - base, busy);
        end
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, 3);
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 1 || dq[base] !== 8'hA5 || fq[base] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_vote: got count %0d data %h expected 1 a5",
                     dq.size() - base, dq[base]);
        end
    endtask

    task automatic test_break;
        int base;
        base = dq.size();
        set_cfg(16, 2'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 30 * 16);
        @(negedge sys_clk);
        n_checks++;
        if (dq.size() - base !== 1) begin
            n_fail++; $display("FAIL break_count: got %0d expected 1", dq.size() - base);
        end
        n_checks++;
        if (dq[base] !== 8'h00 || bq[base] !== 1'b1 || fq[base] !== 1'b1) begin
            n_fail++;
            $display("FAIL break_fields: got data %h brk %b ferr %b expected 00 1 1",
                     dq[base], bq[base], fq[base]);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL break_wait_busy: got %b expected 1", busy);
        end
        drive(1'b1, 30);
        send_frame(8'h5A, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 2 || dq[base+1] !== 8'h5A || bq[base+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL break_recover: got count %0d data %h expected 2 5a",
                     dq.size() - base, dq[base+1]);
        end
    endtask

    task automatic test_reset_abort;
        int base;
        base = dq.size();
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b1, 8);
        #1 sys_rst_n = 1'b0;
        rx = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (busy !== 1'b0 || po_data !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_reset_state: got busy %b data %h expected 0 00", busy, po_data);
        end
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        drive(1'b1, 40);
        n_checks++;
        if (dq.size() != base) begin
            n_fail++; $display("FAIL abort_no_flag: got %0d expected 0", dq.size() - base);
        end
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 1 || dq[base] !== 8'h3C) begin
            n_fail++;
            $display("FAIL abort_next_frame: got count %0d data %h expected 1 3c",
                     dq.size() - base, dq[base]);
        end
    endtask

    task automatic test_cfg_change;
        int base;
        base = dq.size();
        set_cfg(16, 2'd3, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8'h96, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 16, -1);
            begin
                repeat (40) @(posedge sys_clk);
                #2 cfg_div = 16'd32;
            end
        join
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 1 || dq[base] !== 8'h96 || fq[base] !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_shadow: got count %0d data %h expected 1 96",
                     dq.size() - base, dq[base]);
        end
        // Divisors below 8 are clamped to 8 clocks per bit.
        set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
        send_frame(8'h6B, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8, -1);
        drive(1'b1, 20);
        n_checks++;
        if (dq.size() - base !== 2 || dq[base+1] !== 8'h6B) begin
            n_fail++;
            $display("FAIL min_div: got count %0d data %h expected 2 6b",
                     dq.size() - base, dq[base+1]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_stop_bits();
        test_glitch();
        test_break();
        test_reset_abort();
        test_cfg_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
